issue_select: RTL and testbench
===============================

Name: issue_select

Overview:
- Downstream consumer of a bank of capped issue entries.
- Each cycle, picks one ready-to-issue instruction from NUM_ENTRIES entries using round-robin, pops it, and holds it in a registered output stage that feeds the execution unit.
- Provides full-throughput valid/ready decoupling between the issue window and execute, plus a pipeline flush.

Parameters:
- INST_WIDTH, 47, width of one issued instruction word (matches the issue entry payload).
- NUM_ENTRIES, 4, number of issue entries arbitrated; must be ≥2.
- IDX_W, $clog2(NUM_ENTRIES), width of the grant index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- entry_instr  in  NUM_ENTRIES*INST_WIDTH  instruction words; entry i occupies bits [i*INST_WIDTH +: INST_WIDTH].
- entry_valid  in  NUM_ENTRIES  entry i is issuable (capped valid).
- entry_ready  out  NUM_ENTRIES  one-hot pop to the granted entry; all zero when no grant.
- exec_instr  out  INST_WIDTH  registered instruction to execute.
- exec_valid  out  1  exec_instr is valid.
- exec_ready  in  1  execute accepts exec_instr this cycle.
- exec_idx  out  IDX_W  source entry index of exec_instr.
- issue_count  out  16  running count of issued instructions; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - exec_valid=0, exec_instr=0, exec_idx=0.
  - Round-robin pointer rr_ptr=0, issue_count=0.
  - entry_ready=0 while reset is asserted.
- Load enable: load = !flush && (!exec_valid || exec_ready). This gives full throughput: one issue per cycle while execute keeps accepting.
- Grant (combinational):
  - If load and |entry_valid, g is the first i with entry_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_ENTRIES.
  - entry_ready = one-hot(g); otherwise entry_ready=0.
  - entry_ready depends on entry_valid. Entries must not make valid depend on ready; capped entries satisfy this.
- On a grant, at the clock edge:
  - exec_instr ← entry_instr[g], exec_idx ← g, exec_valid ← 1.
  - rr_ptr ← (g+1) mod NUM_ENTRIES.
  - issue_count ← issue_count+1.
- Load with no valid entry: exec_valid ← 0. exec_instr, exec_idx and rr_ptr hold.
- Stall (exec_valid=1, exec_ready=0): all registers hold and entry_ready=0. exec_instr must stay stable while exec_valid=1.
- Flush=1:
  - exec_valid ← 0 and entry_ready=0; no grant that cycle.
  - rr_ptr holds and issue_count holds.
  - A flush overrides a simultaneous exec_ready.
- rr_ptr wrap: the pointer at NUM_ENTRIES-1 that grants entry NUM_ENTRIES-1 returns to 0. For NUM_ENTRIES not a power of two, the pointer must never reach an out-of-range value.
- issue_count wraps from 0xFFFF to 0x0000 with no flag.
- Reset during a stall discards the held instruction. No pop is emitted.
- Latency: entry_valid to exec_valid is 1 cycle when the output stage is free.

Decomposition:
- Shared package holds:
  - INST_WIDTH default (47) and NUM_ENTRIES default.
  - Issue-window sizing constants used alongside the issue entries.
- Sub-module rr_pick (combinational):
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, grant index, any.
  - Parameterized by NUM_ENTRIES.
- issue_select owns the output register, rr_ptr and the counter.

Test Plan:
- Reset, then entry_valid=4'b0000 and exec_ready=1 -> exec_valid=0, entry_ready=0, issue_count=0 for 5 cycles.
- entry_valid=4'b1111 held, exec_ready=1, entry_instr[i]=i+1 -> exec_idx sequence 0,1,2,3,0; one issue per cycle; issue_count=5 after 5 grants.
- Start rr_ptr=2 (after 2 grants), entry_valid=4'b0011 -> grant wraps to idx 0, then idx 1; entry_ready one-hot 4'b0001 then 4'b0010.
- exec_valid=1 holding instr 0x1234, exec_ready=0 for 3 cycles, entry_valid=4'b1111 -> entry_ready=0, exec_instr stable at 0x1234; release -> next grant the following cycle.
- flush=1 together with exec_ready=1 and entry_valid=4'b0100 -> next cycle exec_valid=0, no pop, rr_ptr unchanged; flush=0 -> idx 2 granted.
- Preload issue_count to 0xFFFF via 65535 issues, then one more issue -> count 0x0000. Then assert rst asynchronously mid-stall -> exec_valid drops immediately with no clock edge.

Source files
------------

// File: rtl/issue_select_pkg.sv
// Shared sizing for the issue window and the issue-select output stage.
package issue_select_pkg;

   localparam int INST_WIDTH_DEF  = 47;
   localparam int NUM_ENTRIES_DEF = 4;
   localparam int ISSUE_CNT_W     = 16;

   // Issue-window sizing used alongside the capped issue entries.
   localparam int ENTRY_DEPTH     = 2;
   localparam int WINDOW_SLOTS    = NUM_ENTRIES_DEF * ENTRY_DEPTH;

   // Pointer advance modulo n; never produces an out-of-range value for non-power-of-two n.
   function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
      return (p + 1 >= n) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/issue_select_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick
   import issue_select_pkg::*;
#(
   parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] req,
   input  logic [IDX_W-1:0]       start,
   output logic [NUM_ENTRIES-1:0] grant,
   output logic [IDX_W-1:0]       idx,
   output logic                   any
);

   int unsigned pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      pos   = 0;
      any   = |req;
      // Walk offsets from far to near so the closest request to start wins.
      for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
         pos = int'(start) + k;
         if (pos >= NUM_ENTRIES) pos = pos - NUM_ENTRIES;
         if (req[pos]) idx = IDX_W'(pos);
      end
      if (any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/issue_select.sv
// Round-robin issue select with a registered, fully decoupled execute stage.
module issue_select
   import issue_select_pkg::*;
#(
   parameter int INST_WIDTH  = INST_WIDTH_DEF,
   parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [NUM_ENTRIES*INST_WIDTH-1:0] entry_instr,
   input  logic [NUM_ENTRIES-1:0]            entry_valid,
   output logic [NUM_ENTRIES-1:0]            entry_ready,
   output logic [INST_WIDTH-1:0]             exec_instr,
   output logic                              exec_valid,
   input  logic                              exec_ready,
   output logic [IDX_W-1:0]                  exec_idx,
   output logic [ISSUE_CNT_W-1:0]            issue_count
);

   logic [IDX_W-1:0]       rr_ptr;
   logic [NUM_ENTRIES-1:0] pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;
   logic                   load;
   logic                   issue;
   logic [INST_WIDTH-1:0]  pick_instr;
   logic [IDX_W-1:0]       ptr_next;

   rr_pick #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_rr_pick (
      .req   (entry_valid),
      .start (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Output stage takes a new word when empty or draining; flush wins over exec_ready.
   assign load  = !flush && (!exec_valid || exec_ready);
   assign issue = load && pick_any && rst;

   assign entry_ready = issue ? pick_grant : '0;
   assign pick_instr  = entry_instr[pick_idx*INST_WIDTH +: INST_WIDTH];
   assign ptr_next    = IDX_W'(wrap_inc(int'(pick_idx), NUM_ENTRIES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exec_valid  <= 1'b0;
         exec_instr  <= '0;
         exec_idx    <= '0;
         rr_ptr      <= '0;
         issue_count <= '0;
      end else if (flush) begin
         exec_valid <= 1'b0;
      end else if (load) begin
         exec_valid <= pick_any;
         if (pick_any) begin
            exec_instr  <= pick_instr;
            exec_idx    <= pick_idx;
            rr_ptr      <= ptr_next;
            issue_count <= issue_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select with hand-computed expectations.
module tb_issue_select;
   import issue_select_pkg::*;

   localparam int IW = 47;
   localparam int NE = 4;
   localparam int IXW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [NE*IW-1:0]  entry_instr;
   logic [NE-1:0]     entry_valid;
   logic [NE-1:0]     entry_ready;
   logic [IW-1:0]     exec_instr;
   logic              exec_valid;
   logic              exec_ready;
   logic [IXW-1:0]    exec_idx;
   logic [15:0]       issue_count;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_cnt;

   issue_select #(.INST_WIDTH(IW), .NUM_ENTRIES(NE), .IDX_W(IXW)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .entry_instr (entry_instr),
      .entry_valid (entry_valid),
      .entry_ready (entry_ready),
      .exec_instr  (exec_instr),
      .exec_valid  (exec_valid),
      .exec_ready  (exec_ready),
      .exec_idx    (exec_idx),
      .issue_count (issue_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One accepted issue: check pop before the edge, output stage after it.
   task automatic issue_one(input string tag, input int idx, input logic [IW-1:0] instr);
      logic [NE-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      #1;
      chk({tag, "_rdy"}, 64'(entry_ready), 64'(oh));
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      chk({tag, "_vld"}, 64'(exec_valid), 64'd1);
      chk({tag, "_idx"}, 64'(exec_idx), 64'(idx));
      chk({tag, "_ins"}, 64'(exec_instr), 64'(instr));
      chk({tag, "_cnt"}, 64'(issue_count), 64'(exp_cnt));
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; exec_ready = 1'b1;
      entry_valid = 4'b1111;
      entry_instr = '0;
      for (int i = 0; i < NE; i++) entry_instr[i*IW +: IW] = IW'(i + 1);
      exp_cnt = '0;
      #2;
      chk("rst_rdy", 64'(entry_ready), 64'd0);
      chk("rst_vld", 64'(exec_valid), 64'd0);
      cyc(); cyc();
      chk("rst_rdy2", 64'(entry_ready), 64'd0);
      entry_valid = 4'b0000;
      rst = 1'b1;

      // idle after reset
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("idle_rdy", 64'(entry_ready), 64'd0);
         cyc();
         chk("idle_vld", 64'(exec_valid), 64'd0);
         chk("idle_cnt", 64'(issue_count), 64'd0);
      end

      // full throughput rotation 0,1,2,3,0
      entry_valid = 4'b1111;
      for (int k = 0; k < 5; k++) issue_one("rot", k % 4, IW'((k % 4) + 1));
      chk("rot_cnt5", 64'(issue_count), 64'd5);
      // one more grant (idx 1) leaves the pointer at 2
      issue_one("adv", 1, IW'(2));

      // wrap from pointer 2 with only low entries valid
      entry_valid = 4'b0011;
      issue_one("wrap0", 0, IW'(1));
      issue_one("wrap1", 1, IW'(2));

      // load 0x1234 from entry 2, then stall
      entry_instr[2*IW +: IW] = IW'(16'h1234);
      entry_valid = 4'b0100;
      issue_one("ld", 2, IW'(16'h1234));
      exec_ready = 1'b0;
      entry_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_rdy", 64'(entry_ready), 64'd0);
         cyc();
         chk("stall_vld", 64'(exec_valid), 64'd1);
         chk("stall_ins", 64'(exec_instr), 64'h1234);
         chk("stall_cnt", 64'(issue_count), 64'(exp_cnt));
      end
      exec_ready = 1'b1;
      issue_one("rel", 3, IW'(4));

      // flush beats exec_ready; pointer (0) must not move
      flush = 1'b1;
      entry_valid = 4'b0100;
      #1;
      chk("fl_rdy", 64'(entry_ready), 64'd0);
      cyc();
      chk("fl_vld", 64'(exec_valid), 64'd0);
      chk("fl_cnt", 64'(issue_count), 64'(exp_cnt));
      flush = 1'b0;
      entry_valid = 4'b1100;
      issue_one("postfl", 2, IW'(16'h1234));

      // load with nothing valid: valid drops, idx holds
      entry_valid = 4'b0000;
      cyc();
      chk("empty_vld", 64'(exec_valid), 64'd0);
      chk("empty_idx", 64'(exec_idx), 64'd2);
      chk("empty_cnt", 64'(issue_count), 64'(exp_cnt));

      // run the counter up to 0xFFFF, then wrap
      entry_valid = 4'b1111;
      while (exp_cnt != 16'hFFFF) begin
         cyc();
         exp_cnt = exp_cnt + 16'd1;
      end
      chk("cnt_max", 64'(issue_count), 64'hFFFF);
      cyc();
      chk("cnt_wrap", 64'(issue_count), 64'h0000);
      chk("cnt_wrap_vld", 64'(exec_valid), 64'd1);

      // async reset mid-stall
      exec_ready = 1'b0;
      cyc();
      chk("pre_rst_vld", 64'(exec_valid), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_vld", 64'(exec_valid), 64'd0);
      chk("arst_ins", 64'(exec_instr), 64'd0);
      chk("arst_cnt", 64'(issue_count), 64'd0);
      chk("arst_rdy", 64'(entry_ready), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
